// File: rtl/sgm_path_cost_engine.sv
// SGM single-direction path-cost aggregator: horizontal (previous pixel) or vertical
// (previous line via a line buffer) recurrence, one-cycle latency, saturating costs.
module sgm_path_cost_engine #(
    parameter int DISPARITY_LEVELS = 64,
    parameter int COST_BITS        = 6,
    parameter int ACC_COST_BITS    = 9,
    parameter int PENALTY_BITS     = 8,
    parameter int MAX_LINE         = 1024,
    parameter int LINE_LEN_BITS    = 11
) (
    input  logic                                    in_clk,
    input  logic                                    in_rst_n,
    input  logic                                    in_valid,
    input  logic                                    in_sof,
    input  logic                                    in_sol,
    input  logic                                    in_mode,
    input  logic [LINE_LEN_BITS-1:0]                in_line_len,
    input  logic [PENALTY_BITS-1:0]                 in_P1,
    input  logic [PENALTY_BITS-1:0]                 in_P2,
    input  logic [COST_BITS*DISPARITY_LEVELS-1:0]   in_C_arr,
    output logic                                    out_valid,
    output logic [ACC_COST_BITS*DISPARITY_LEVELS-1:0] out_L_arr,
    output logic [ACC_COST_BITS-1:0]                out_min_L,
    output logic                                    out_path_start
);
    localparam int D        = DISPARITY_LEVELS;
    localparam int AW       = ACC_COST_BITS;
    localparam int SW       = ACC_COST_BITS + 2;
    localparam int PTR_BITS = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
    localparam logic [SW-1:0]            SAT     = {2'b00, {AW{1'b1}}};
    localparam logic [LINE_LEN_BITS-1:0] LEN_ONE = LINE_LEN_BITS'(1);
    localparam logic [LINE_LEN_BITS-1:0] LEN_MAX = LINE_LEN_BITS'(MAX_LINE);

    if (ACC_COST_BITS < COST_BITS) begin : g_bad_acc_width
        $error("ACC_COST_BITS must be >= COST_BITS");
    end
    if (DISPARITY_LEVELS < 2) begin : g_bad_levels
        $error("DISPARITY_LEVELS must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, RUN_H, FIRST_LINE, RUN_V} state_e;

    state_e                   state_q, state_d, eff_state;
    logic [PTR_BITS-1:0]      ptr_q, ptr_d, eff_ptr;
    logic [LINE_LEN_BITS-1:0] len_q, len_d, eff_len, len_clamped;
    logic                     accept, path_begin, last_col;
    logic [D*AW-1:0]          l_q, l_new, lp;
    logic [AW-1:0]            min_q, min_new, m;
    logic                     valid_q, ps_q;
    logic [AW-1:0]            lp_a [D];
    logic [SW-1:0]            s, sum, p1, p2;
    logic [D*AW-1:0]          line_mem [MAX_LINE];

    // NOTE: every variable gets a default at the top of always_comb, so no path infers a latch.
    always_comb begin
        len_clamped = in_line_len;
        if (in_line_len == '0) begin
            len_clamped = LEN_ONE;
        end else if (in_line_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    // A sof beat behaves as if the new mode and length were already latched.
    always_comb begin
        accept     = in_valid && (in_sof || state_q != IDLE);
        eff_state  = in_sof ? (in_mode ? FIRST_LINE : RUN_H) : state_q;
        eff_len    = in_sof ? len_clamped : len_q;
        eff_ptr    = in_sof ? '0 : ptr_q;
        last_col   = (LINE_LEN_BITS'(eff_ptr) == eff_len - LEN_ONE);
        path_begin = (eff_state == FIRST_LINE) || (eff_state == RUN_H && (in_sof || in_sol));
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = eff_state;
            len_d   = eff_len;
            ptr_d   = eff_ptr;
            if (eff_state != RUN_H) begin
                ptr_d = last_col ? '0 : eff_ptr + PTR_BITS'(1);
                if (eff_state == FIRST_LINE && last_col) begin
                    state_d = RUN_V;
                end
            end
        end
    end

    // Missing edge neighbours reuse Lp[d] itself; Lp[d]+P1 can never beat Lp[d].
    always_comb begin
        lp      = (eff_state == RUN_V) ? line_mem[eff_ptr] : l_q;
        p1      = SW'(in_P1);
        p2      = SW'(in_P2);
        m       = '1;
        l_new   = '0;
        min_new = '1;
        s       = '0;
        sum     = '0;
        for (int d = 0; d < D; d++) begin
            lp_a[d] = lp[d*AW +: AW];
            if (lp_a[d] < m) m = lp_a[d];
        end
        for (int d = 0; d < D; d++) begin
            s = SW'(lp_a[d]);
            if (SW'(lp_a[(d == 0) ? 0 : d - 1]) + p1 < s) s = SW'(lp_a[(d == 0) ? 0 : d - 1]) + p1;
            if (SW'(lp_a[(d == D - 1) ? d : d + 1]) + p1 < s) s = SW'(lp_a[(d == D - 1) ? d : d + 1]) + p1;
            if (SW'(m) + p2 < s) s = SW'(m) + p2;
            sum = SW'(in_C_arr[d*COST_BITS +: COST_BITS]) + s - SW'(m);
            if (path_begin) begin
                l_new[d*AW +: AW] = AW'(in_C_arr[d*COST_BITS +: COST_BITS]);
            end else if (sum > SAT) begin
                l_new[d*AW +: AW] = {AW{1'b1}};
            end else begin
                l_new[d*AW +: AW] = sum[AW-1:0];
            end
            if (l_new[d*AW +: AW] < min_new) min_new = l_new[d*AW +: AW];
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= LEN_ONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            valid_q <= 1'b0;
            l_q     <= '0;
            min_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                l_q   <= l_new;
                min_q <= min_new;
                ps_q  <= path_begin;
            end
        end
    end

    // NOTE: the line buffer has no reset; each entry is written on the first line before it is read.
    always_ff @(posedge in_clk) begin
        if (accept && eff_state != RUN_H) begin
            line_mem[eff_ptr] <= l_new;
        end
    end

    assign out_valid      = valid_q;
    assign out_L_arr      = l_q;
    assign out_min_L      = min_q;
    assign out_path_start = ps_q;
endmodule

// File: tb/tb_sgm_path_cost_engine.sv
// Scoreboard bench for sgm_path_cost_engine: a behavioural model queues expected results
// per accepted beat; they are popped when the DUT raises out_valid.
module tb_sgm_path_cost_engine;
    localparam int D  = 4;
    localparam int CB = 6;
    localparam int AB = 8;
    localparam int PB = 8;
    localparam int ML = 8;
    localparam int LB = 11;
    localparam int SATV = (1 << AB) - 1;
    localparam int M_IDLE = 0, M_RUN_H = 1, M_FIRST = 2, M_RUN_V = 3;

    logic          in_clk = 1'b0;
    logic          in_rst_n = 1'b0;
    logic          in_valid = 1'b0, in_sof = 1'b0, in_sol = 1'b0, in_mode = 1'b0;
    logic [LB-1:0] in_line_len = '0;
    logic [PB-1:0] in_P1 = '0, in_P2 = '0;
    logic [CB*D-1:0] in_C_arr = '0;
    logic            out_valid;
    logic [AB*D-1:0] out_L_arr;
    logic [AB-1:0]   out_min_L;
    logic            out_path_start;

    sgm_path_cost_engine #(
        .DISPARITY_LEVELS(D), .COST_BITS(CB), .ACC_COST_BITS(AB),
        .PENALTY_BITS(PB), .MAX_LINE(ML), .LINE_LEN_BITS(LB)
    ) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_sol(in_sol), .in_mode(in_mode), .in_line_len(in_line_len), .in_P1(in_P1),
        .in_P2(in_P2), .in_C_arr(in_C_arr), .out_valid(out_valid), .out_L_arr(out_L_arr),
        .out_min_L(out_min_L), .out_path_start(out_path_start)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [AB*D-1:0] l;
        logic [AB-1:0]   mn;
        logic            ps;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    int m_state = M_IDLE;
    int m_len = 1;
    int m_ptr = 0;
    int m_prev[D];
    int m_buf[ML][D];
    logic [AB*D-1:0] last_l = '0;
    logic [AB-1:0]   last_min = '0;
    int cfg_mode = 0, cfg_len = 1, cfg_p1 = 0, cfg_p2 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AB*D-1:0] pk(input int a, input int b, input int c, input int d);
        return {AB'(d), AB'(c), AB'(b), AB'(a)};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_len = 1;
        m_ptr = 0;
        for (int d = 0; d < D; d++) m_prev[d] = 0;
        last_l = '0;
        last_min = '0;
        sb_q.delete();
    endtask

    // Drives one cycle, advances the model, then checks the DUT one cycle later.
    task automatic beat(input bit v, input bit sof, input bit sol,
                        input int c0, input int c1, input int c2, input int c3);
        int c[D];
        int lp[D];
        int l[D];
        int m, s, mn, eff, ptr, len;
        bit acc, pb;
        exp_t e;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        in_valid = v;
        in_sof = sof;
        in_sol = sol;
        in_mode = cfg_mode[0];
        in_line_len = LB'(cfg_len);
        in_P1 = PB'(cfg_p1);
        in_P2 = PB'(cfg_p2);
        in_C_arr = {CB'(c3), CB'(c2), CB'(c1), CB'(c0)};
        acc = v && (sof || m_state != M_IDLE);
        if (acc) begin
            if (sof) begin
                len = (cfg_len < 1) ? 1 : ((cfg_len > ML) ? ML : cfg_len);
                eff = cfg_mode[0] ? M_FIRST : M_RUN_H;
                ptr = 0;
            end else begin
                len = m_len;
                eff = m_state;
                ptr = m_ptr;
            end
            pb = (eff == M_FIRST) || (eff == M_RUN_H && (sof || sol));
            for (int d = 0; d < D; d++) lp[d] = (eff == M_RUN_V) ? m_buf[ptr][d] : m_prev[d];
            m = lp[0];
            for (int d = 1; d < D; d++) if (lp[d] < m) m = lp[d];
            for (int d = 0; d < D; d++) begin
                if (pb) begin
                    l[d] = c[d];
                end else begin
                    s = lp[d];
                    if (d > 0 && lp[d-1] + cfg_p1 < s) s = lp[d-1] + cfg_p1;
                    if (d < D - 1 && lp[d+1] + cfg_p1 < s) s = lp[d+1] + cfg_p1;
                    if (m + cfg_p2 < s) s = m + cfg_p2;
                    l[d] = c[d] + s - m;
                    if (l[d] > SATV) l[d] = SATV;
                end
            end
            mn = l[0];
            for (int d = 1; d < D; d++) if (l[d] < mn) mn = l[d];
            m_state = eff;
            if (eff != M_RUN_H) begin
                for (int d = 0; d < D; d++) m_buf[ptr][d] = l[d];
                if (eff == M_FIRST && ptr == len - 1) m_state = M_RUN_V;
                m_ptr = (ptr == len - 1) ? 0 : ptr + 1;
            end
            m_len = len;
            for (int d = 0; d < D; d++) m_prev[d] = l[d];
            e.l = pk(l[0], l[1], l[2], l[3]);
            e.mn = AB'(mn);
            e.ps = pb;
            sb_q.push_back(e);
        end
        @(posedge in_clk);
        #1;
        check("out_valid", out_valid, acc);
        if (out_valid) begin
            check("sb_nonempty", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("L", out_L_arr, e.l);
                check("min_L", out_min_L, e.mn);
                check("path_start", out_path_start, e.ps);
                last_l = e.l;
                last_min = e.mn;
            end
        end else begin
            check("hold_L", out_L_arr, last_l);
            check("hold_min", out_min_L, last_min);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic vline(input bit first, input int n, input int c0, input int c1, input int c2, input int c3);
        for (int i = 0; i < n; i++) beat(1'b1, first && i == 0, i == 0, c0, c1, c2, c3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_L", out_L_arr, 0);
        check("rst_min", out_min_L, 0);
        check("rst_ps", out_path_start, 0);
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        in_rst_n = 1'b1;

        // IDLE drops valid beats without sof.
        beat(1'b1, 1'b0, 1'b0, 1, 2, 3, 4);

        // Horizontal basic.
        cfg_mode = 0; cfg_len = 8; cfg_p1 = 5; cfg_p2 = 20;
        beat(1'b1, 1'b1, 1'b1, 10, 20, 30, 40);
        check("hb_L0", out_L_arr, pk(10, 20, 30, 40));
        check("hb_min0", out_min_L, 10);
        check("hb_ps0", out_path_start, 1);
        beat(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("hb_L1", out_L_arr, pk(0, 5, 15, 20));
        check("hb_min1", out_min_L, 0);
        check("hb_ps1", out_path_start, 0);

        // Saturation.
        cfg_p1 = 255; cfg_p2 = 255;
        beat(1'b1, 1'b1, 1'b1, 0, 63, 63, 63);
        beat(1'b1, 1'b0, 1'b0, 0, 63, 63, 63);
        check("sat_b2", out_L_arr, pk(0, 126, 126, 126));
        beat(1'b1, 1'b0, 1'b0, 0, 63, 63, 63);
        check("sat_b3", out_L_arr, pk(0, 189, 189, 189));
        beat(1'b1, 1'b0, 1'b0, 0, 63, 63, 63);
        beat(1'b1, 1'b0, 1'b0, 0, 63, 63, 63);
        check("sat_b5", out_L_arr, pk(0, 255, 255, 255));

        // Vertical, len 3.
        cfg_mode = 1; cfg_len = 3; cfg_p1 = 5; cfg_p2 = 20;
        vline(1'b1, 3, 10, 20, 30, 40);
        check("v_line0_ps", out_path_start, 1);
        vline(1'b0, 3, 0, 0, 0, 0);
        check("v_line1_L", out_L_arr, pk(0, 5, 15, 20));
        check("v_line1_ps", out_path_start, 0);

        // Gaps in horizontal mode.
        cfg_mode = 0;
        beat(1'b1, 1'b1, 1'b1, 10, 20, 30, 40);
        idle(4);
        beat(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("gap_h_L", out_L_arr, pk(0, 5, 15, 20));

        // Gaps in vertical mode.
        cfg_mode = 1;
        vline(1'b1, 3, 10, 20, 30, 40);
        beat(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        idle(4);
        beat(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        beat(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("gap_v_L", out_L_arr, pk(0, 5, 15, 20));

        // Reset mid-line 1, then restart.
        vline(1'b1, 3, 10, 20, 30, 40);
        beat(1'b1, 1'b0, 1'b1, 3, 3, 3, 3);
        #2;
        in_valid = 1'b0;
        in_rst_n = 1'b0;
        #1;
        check("amid_valid", out_valid, 0);
        check("amid_L", out_L_arr, 0);
        check("amid_min", out_min_L, 0);
        check("amid_ps", out_path_start, 0);
        model_reset();
        @(negedge in_clk);
        in_rst_n = 1'b1;
        beat(1'b1, 1'b0, 1'b1, 1, 2, 3, 4);
        beat(1'b1, 1'b0, 1'b0, 1, 2, 3, 4);
        beat(1'b1, 1'b1, 1'b1, 7, 8, 9, 10);
        check("restart_L", out_L_arr, pk(7, 8, 9, 10));
        check("restart_ps", out_path_start, 1);
        vline(1'b0, 2, 7, 8, 9, 10);
        check("restart_first_line_ps", out_path_start, 1);

        // Length 0 clamps to 1.
        cfg_len = 0;
        beat(1'b1, 1'b1, 1'b1, 10, 20, 30, 40);
        beat(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        check("len0_b2", out_L_arr, pk(0, 5, 15, 20));
        beat(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        check("len0_b3", out_L_arr, pk(0, 5, 10, 20));

        // Length 20 clamps to MAX_LINE.
        cfg_len = 20;
        for (int i = 0; i < 2 * ML; i++) begin
            beat(1'b1, i == 0, (i % ML) == 0, $urandom_range(63), $urandom_range(63),
                 $urandom_range(63), $urandom_range(63));
            if (i == ML - 1) check("len20_last_first_line_ps", out_path_start, 1);
            if (i == ML) check("len20_second_line_ps", out_path_start, 0);
        end

        // Horizontal sol restarts the path.
        cfg_mode = 0; cfg_len = 4;
        beat(1'b1, 1'b1, 1'b1, 10, 20, 30, 40);
        beat(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        beat(1'b1, 1'b0, 1'b1, 5, 6, 7, 8);
        check("sol_L", out_L_arr, pk(5, 6, 7, 8));
        check("sol_ps", out_path_start, 1);

        // Random streams with penalty changes, sol and gaps in both modes.
        for (int mode = 0; mode < 2; mode++) begin
            cfg_mode = mode; cfg_len = 5;
            for (int i = 0; i < 30; i++) begin
                cfg_p1 = $urandom_range(30);
                cfg_p2 = $urandom_range(255);
                if (i > 0 && $urandom_range(3) == 0) idle(1);
                beat(1'b1, i == 0, (i % 5) == 0, $urandom_range(63), $urandom_range(63),
                     $urandom_range(63), $urandom_range(63));
            end
        end
        idle(2);
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sgm_path_cost_engine.md
Name: sgm_path_cost_engine

Overview:
- Parametrised SGM single-direction path-cost aggregator; successor to the fixed-delay path cost calculator.
- Adds valid-qualified streaming, saturating accumulation and a frame-level FSM.
- Adds runtime selection between horizontal recurrence (previous pixel) and vertical recurrence (same column, previous line), with a runtime line length.
- Sits between the local matching-cost stage and the multi-path cost summer.

Parameters:
DISPARITY_LEVELS, 64, number of candidate disparities D (>=2)
COST_BITS, 6, width of each local cost
ACC_COST_BITS, 9, width of each path cost (>= COST_BITS, else elaboration error)
PENALTY_BITS, 8, width of P1/P2
MAX_LINE, 1024, line buffer depth (max pixels per line)
LINE_LEN_BITS, 11, width of in_line_len (must hold MAX_LINE)

Ports:
in_clk  input  1  clock, all logic on rising edge
in_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  beat qualifier for in_C_arr/in_sof/in_sol
in_sof  input  1  first pixel of frame; latches mode and line length
in_sol  input  1  first pixel of line
in_mode  input  1  0 = horizontal, 1 = vertical; sampled on the sof beat
in_line_len  input  LINE_LEN_BITS  pixels per line; sampled on the sof beat
in_P1  input  PENALTY_BITS  small penalty
in_P2  input  PENALTY_BITS  large penalty
in_C_arr  input  COST_BITS*D  packed local costs, d at [COST_BITS*d +: COST_BITS]
out_valid  output  1  new path costs on out_L_arr
out_L_arr  output  ACC_COST_BITS*D  packed path costs, same packing
out_min_L  output  ACC_COST_BITS  minimum over out_L_arr
out_path_start  output  1  out_L_arr equals the input costs (path beginning)

Behaviour:
- Reset (async, in_rst_n=0): out_valid=0, out_L_arr=0, out_min_L=0, out_path_start=0, state=IDLE, pointer=0, latched mode=0, latched length=1. Line buffer contents are don't-care. Release is synchronous to in_clk.
- Latency: one cycle. An accepted beat at edge n produces out_valid=1 after edge n+1. Beats with in_valid=0 change nothing. out_L_arr/out_min_L hold their values and out_valid=0.
- FSM states: IDLE, RUN_H, FIRST_LINE, RUN_V.
  - IDLE: valid beats without sof are dropped, out_valid stays 0.
  - valid&sof from any state: latch in_mode and the clamped length, set pointer=0. Next state is RUN_H (mode 0) or FIRST_LINE (mode 1). The sof beat itself is processed as a path beginning.
  - FIRST_LINE -> RUN_V when the beat at pointer = len-1 is accepted.
  - RUN_H and RUN_V persist until the next sof or reset.
- Length clamp: 0 -> 1; values > MAX_LINE -> MAX_LINE.
- Path beginning:
  - RUN_H: sof or sol beat.
  - FIRST_LINE: every beat.
  - RUN_V: never.
  - On a path beginning, L[d] = C[d] (zero-extended), out_path_start=1.
- Previous costs Lp:
  - RUN_H: last registered out_L_arr.
  - RUN_V: line buffer entry at pointer, written len accepted beats earlier.
- Pointer handling (vertical mode): each accepted beat writes the new L to the line buffer at the pointer on the same edge (read-before-write). The pointer then increments and wraps len-1 -> 0. The pointer is unused in horizontal mode.
- Recurrence (d = 0..D-1):
  - m = min over d of Lp[d].
  - S[d] = min(Lp[d], Lp[d-1]+P1, Lp[d+1]+P1, m+P2). Out-of-range neighbours are omitted.
  - L[d] = C[d] + S[d] - m.
  - Sums use ACC_COST_BITS+2 bits. Results > 2^ACC_COST_BITS-1 saturate to all-ones. Subtraction never underflows because S >= m.
- out_min_L: min of the new L, registered together with out_L_arr.
- Penalties are sampled every beat; changing them mid-frame is legal.
- Reset mid-line: outputs drop to 0 immediately. Processing resumes only after the next valid&sof.

Test Plan:
(Bench params: D=4, COST_BITS=6, ACC_COST_BITS=8, MAX_LINE=8; C listed as d0..d3.)
- Horizontal basic: mode0, P1=5, P2=20. Sof beat C={10,20,30,40} -> L={10,20,30,40}, min=10, path_start=1. Next beat C={0,0,0,0} -> L={0,5,15,20}, min=0, path_start=0.
- Saturation: mode0, P1=P2=255, every beat C={0,63,63,63}. Beats 1..5 give L[1..3] = 63, 126, 189, 252, 255; L[0]=0 throughout.
- Vertical: mode1, len=3, P1=5, P2=20. Line 0 C={10,20,30,40} each beat -> outputs equal C, path_start=1. Line 1 C=0 -> {0,5,15,20} per column, path_start=0.
- Gaps: insert 4 idle cycles mid-line in both modes -> out_valid=0 during gaps, outputs held, subsequent results identical to the gap-free run.
- Reset/restart: assert in_rst_n=0 mid-line 1 -> all outputs 0 asynchronously. Valid beats without sof -> out_valid=0. Then sof -> FIRST_LINE behaviour again.
- Clamp/sol: len=0 in mode1 -> every beat after the first uses the previous beat (len 1). len=20 -> behaves as 8. Mode0 sol on beat 3 -> path_start=1, L=C.
